// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control : multi-cycle MIPS main control FSM with memory stalls,
// illegal-opcode detection and a retired-instruction counter.   Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Mem_Ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic [1:0]          PCSource,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                RegWrite,
  output logic                RegDst,
  output logic [3:0]          State,
  output logic                Illegal,
  output logic [CNT_W-1:0]    Instr_Count
);

  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12
  } state_t;

  state_t state;
  logic   retire;

  // An instruction retires on the edge that leaves its final state.
  assign retire = (state inside {S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB}) ||
                  (state == S_MEMWR && Mem_Ready);

  assign State = state;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_RST;
      Illegal     <= 1'b0;
      Instr_Count <= '0;
    end else begin
      Illegal <= 1'b0;
      if (retire)
        Instr_Count <= Instr_Count + CNT_W'(1);
      case (state)
        S_RST:     state <= S_FETCH;
        S_FETCH:   if (Mem_Ready) state <= S_DECODE;
        S_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            OP_ADDI:      state <= S_ADDI_EX;
            default: begin
              state   <= S_FETCH;
              Illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:  state <= (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (Mem_Ready) state <= S_MEMWB;
        S_MEMWR:   if (Mem_Ready) state <= S_FETCH;
        S_EXEC:    state <= S_RWB;
        S_ADDI_EX: state <= S_ADDI_WB;
        S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: state <= S_FETCH;
        default: begin
          // Codes 13-15 can only come from upset; recover through fetch.
          state   <= S_FETCH;
          Illegal <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = 2'd0;
    ALUOp       = '0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = Mem_Ready;
        PCWrite = Mem_Ready;
      end
      S_DECODE:  ALUSrcB = 2'd3;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(2);
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_W'(1);
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for multicycle_control: per-instruction expected traces drive the
// inputs and are compared against two instances (CNT_W=16 and CNT_W=4).
module tb_multicycle_control;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;

  logic       pcw[2], pcwc[2], iord[2], mrd[2], mwr[2], irw[2], m2r[2];
  logic       srca[2], regw[2], regd[2], ill[2];
  logic [1:0] pcsrc[2], aluop[2], srcb[2];
  logic [3:0] st[2];
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  multicycle_control dut (
    .Clock(clk), .Reset_n(rst_n), .Opcode(opcode), .Mem_Ready(mem_ready),
    .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .IorD(iord[0]), .MemRead(mrd[0]),
    .MemWrite(mwr[0]), .IRWrite(irw[0]), .MemtoReg(m2r[0]), .PCSource(pcsrc[0]),
    .ALUOp(aluop[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]), .RegWrite(regw[0]),
    .RegDst(regd[0]), .State(st[0]), .Illegal(ill[0]), .Instr_Count(cnt16)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .Clock(clk), .Reset_n(rst_n), .Opcode(opcode), .Mem_Ready(mem_ready),
    .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .IorD(iord[1]), .MemRead(mrd[1]),
    .MemWrite(mwr[1]), .IRWrite(irw[1]), .MemtoReg(m2r[1]), .PCSource(pcsrc[1]),
    .ALUOp(aluop[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]), .RegWrite(regw[1]),
    .RegDst(regd[1]), .State(st[1]), .Illegal(ill[1]), .Instr_Count(cnt4)
  );

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r;
    logic [1:0] pcsrc, aluop;
    logic srca;
    logic [1:0] srcb;
    logic regw, regd;
  } ctrl_t;

  typedef struct {
    bit         rst_n;
    bit         mr;
    logic [5:0] op;
    int         st;
    bit         ill;
    int         cnt;
  } ent_t;

  int n_checks = 0, n_fail = 0;
  ent_t trace[$];
  ent_t cur;
  bit   cur_valid = 1'b0;
  int   mcnt = 0;
  bit   pend_ill = 1'b0;
  logic [5:0] cur_op = 6'd0;
  int   mon_mwr = 0, mon_ill = 0, mon_irw = 0, mon_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Control outputs each state must present, straight from the state table.
  function automatic ctrl_t exp_ctrl(input int s, input bit mr);
    ctrl_t c = '0;
    case (s)
      1:  begin c.mrd = 1; c.srcb = 2'd1; c.irw = mr; c.pcw = mr; end
      2:  c.srcb = 2'd3;
      3:  begin c.srca = 1; c.srcb = 2'd2; end
      4:  begin c.mrd = 1; c.iord = 1; end
      5:  begin c.regw = 1; c.m2r = 1; end
      6:  begin c.mwr = 1; c.iord = 1; end
      7:  begin c.srca = 1; c.aluop = 2'd2; end
      8:  begin c.regw = 1; c.regd = 1; end
      9:  begin c.srca = 1; c.aluop = 2'd1; c.pcwc = 1; c.pcsrc = 2'd1; end
      10: begin c.pcw = 1; c.pcsrc = 2'd2; end
      11: begin c.srca = 1; c.srcb = 2'd2; end
      12: c.regw = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t ctrl_of(input int i);
    ctrl_t c;
    c.pcw = pcw[i]; c.pcwc = pcwc[i]; c.iord = iord[i]; c.mrd = mrd[i];
    c.mwr = mwr[i]; c.irw = irw[i]; c.m2r = m2r[i]; c.pcsrc = pcsrc[i];
    c.aluop = aluop[i]; c.srca = srca[i]; c.srcb = srcb[i];
    c.regw = regw[i]; c.regd = regd[i];
    return c;
  endfunction

  task automatic push(input int s, input bit mr, input bit rn);
    ent_t e;
    e.rst_n = rn; e.mr = mr; e.op = cur_op; e.st = s;
    e.ill = pend_ill; e.cnt = mcnt;
    trace.push_back(e);
    pend_ill = 1'b0;
  endtask

  task automatic add_reset(input int cycles);
    mcnt = 0;
    pend_ill = 1'b0;
    repeat (cycles) push(0, 1'b1, 1'b0);
    push(0, 1'b1, 1'b1);
  endtask

  // One instruction: fs fetch-stall cycles, ms memory-stall cycles.
  task automatic add_instr(input logic [5:0] op, input int fs, input int ms);
    cur_op = op;
    repeat (fs) push(1, 1'b0, 1'b1);
    push(1, 1'b1, 1'b1);
    push(2, 1'b0, 1'b1);
    case (op)
      LW:   begin push(3, 1, 1); repeat (ms) push(4, 0, 1); push(4, 1, 1); push(5, 0, 1); mcnt++; end
      SW:   begin push(3, 0, 1); repeat (ms) push(6, 0, 1); push(6, 1, 1); mcnt++; end
      RT:   begin push(7, 0, 1); push(8, 1, 1); mcnt++; end
      BEQ:  begin push(9, 1, 1); mcnt++; end
      JMP:  begin push(10, 0, 1); mcnt++; end
      ADDI: begin push(11, 1, 1); push(12, 0, 1); mcnt++; end
      default: pend_ill = 1'b1;
    endcase
  endtask

  // A stalled fetch cycle so the last retire is visible once play() returns.
  task automatic pad();
    push(1, 1'b0, 1'b1);
  endtask

  task automatic play();
    mon_mwr = 0; mon_ill = 0; mon_irw = 0; mon_cycles = 0;
    while (trace.size() > 0) begin
      ent_t e = trace.pop_front();
      @(posedge clk);
      #1;
      rst_n = e.rst_n;
      mem_ready = e.mr;
      opcode = e.op;
      cur = e;
      cur_valid = 1'b1;
    end
    @(negedge clk);
    #1 cur_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      check("state", {28'd0, st[0]}, cur.st);
      check("state_c4", {28'd0, st[1]}, cur.st);
      check("ctrl", {16'd0, ctrl_of(0)}, {16'd0, exp_ctrl(cur.st, cur.mr)});
      check("ctrl_c4", {16'd0, ctrl_of(1)}, {16'd0, exp_ctrl(cur.st, cur.mr)});
      check("illegal", {31'd0, ill[0]}, {31'd0, cur.ill});
      check("count16", {16'd0, cnt16}, cur.cnt % 65536);
      check("count4", {28'd0, cnt4}, cur.cnt % 16);
      check("mem_excl", {31'd0, mrd[0] & mwr[0]}, 32'd0);
      mon_cycles++;
      if (mwr[0]) mon_mwr++;
      if (ill[0]) mon_ill++;
      if (irw[0]) mon_irw++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then lw with no stalls: states 0,0,0,1,2,3,4,5 then FETCH.
    add_reset(2);
    add_instr(LW, 0, 0);
    pad();
    check("lw_trace_len", trace.size(), 9);
    play();
    check("lw_count", {16'd0, cnt16}, 1);
    check("lw_back_fetch", {28'd0, st[0]}, 1);

    // R-type, beq, j back to back: 4 + 3 + 3 cycles.
    add_instr(RT, 0, 0);
    add_instr(BEQ, 0, 0);
    add_instr(JMP, 0, 0);
    pad();
    play();
    check("rbj_cycles", mon_cycles, 11);
    check("rbj_count", {16'd0, cnt16}, 4);

    // sw with three stalled cycles in MEMWR.
    add_instr(SW, 0, 3);
    pad();
    play();
    check("sw_memwrite_cycles", mon_mwr, 4);
    check("sw_count", {16'd0, cnt16}, 5);

    // addi after a stalled fetch (pad supplies the first stall cycle).
    add_instr(ADDI, 1, 0);
    pad();
    play();
    check("addi_irwrite_cycles", mon_irw, 1);
    check("addi_count", {16'd0, cnt16}, 6);

    // Illegal opcode: back to FETCH with a one-cycle pulse, no retire.
    add_instr(6'b111111, 0, 0);
    pad();
    add_instr(BEQ, 0, 0);
    pad();
    play();
    check("illegal_pulses", mon_ill, 1);
    check("illegal_count", {16'd0, cnt16}, 7);

    // Reset asserted during a MEMRD stall, then 17 instructions.
    cur_op = LW;
    push(1, 1, 1); push(2, 0, 1); push(3, 1, 1); push(4, 0, 1); push(4, 0, 1);
    add_reset(1);
    for (int i = 0; i < 17; i++) add_instr((i % 2 == 0) ? BEQ : JMP, 0, 0);
    pad();
    play();
    check("wrap_count16", {16'd0, cnt16}, 17);
    check("wrap_count4", {28'd0, cnt4}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle MIPS main control FSM; successor to the single-cycle main decoder.
- Sequences fetch/decode/execute/memory/writeback per instruction and drives the multi-cycle datapath muxes and enables.
- Adds variable-latency memory stalls, illegal-opcode detection and a retired-instruction counter.

Parameters:
OPCODE_W, 6, opcode field width (MIPS encodings below are for 6).
ALUOP_W, 2, ALUOp width; only the low 2 bits are encoded, upper bits are 0.
CNT_W, 16, Instr_Count width.

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
Opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward
Mem_Ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  1=MDR to register file
PCSource  out  2  0=ALU, 1=ALUOut, 2=jump target
ALUOp  out  ALUOP_W  0=add, 1=sub, 2=funct decode
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  0=rt, 1=4, 2=signext imm, 3=signext imm<<2
RegWrite  out  1  register file write
RegDst  out  1  1=rd, 0=rt
State  out  4  current state code (debug)
Illegal  out  1  one-cycle pulse on unknown opcode
Instr_Count  out  CNT_W  retired instructions

Behaviour:
- Reset (Reset_n=0, async):
  - state=RST(0), Instr_Count=0, Illegal=0.
  - All control outputs are 0 while in RST.
- RST -> FETCH unconditionally on the first edge after release.
- Control outputs are a combinational decode of the registered state, qualified by Mem_Ready where noted. Unlisted outputs are 0 in each state.
- States and codes:
  - FETCH(1): MemRead=1, ALUSrcB=1, ALUOp=0, PCSource=0.
    - IRWrite=PCWrite=1 only when Mem_Ready=1.
    - Stay in FETCH while Mem_Ready=0; go to DECODE when Mem_Ready=1.
  - DECODE(2): ALUSrcB=3, ALUOp=0. Next state by Opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EX
    - any other -> FETCH, with Illegal=1 for exactly the next cycle; Instr_Count is not incremented.
  - MEMADR(3): ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next: lw -> MEMRD, sw -> MEMWR (Opcode is held stable by the IR).
  - MEMRD(4): MemRead=1, IorD=1. Stay while Mem_Ready=0; -> MEMWB when Mem_Ready=1.
  - MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWR(6): MemWrite=1, IorD=1. Stay while Mem_Ready=0; -> FETCH when Mem_Ready=1.
  - EXEC(7): ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> RWB(8).
  - RWB(8): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1 -> FETCH.
  - JUMP(10): PCWrite=1, PCSource=2 -> FETCH.
  - ADDI_EX(11): ALUSrcA=1, ALUSrcB=2, ALUOp=0 -> ADDI_WB(12).
  - ADDI_WB(12): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Instruction latency at Mem_Ready=1: lw 5, sw/R/addi 4, beq/j 3 cycles. Each cycle Mem_Ready is low adds one cycle.
- Instr_Count:
  - Increments by 1 on the edge leaving MEMWB, MEMWR (with Mem_Ready=1), RWB, BRANCH, JUMP or ADDI_WB.
  - Wraps modulo 2^CNT_W; no saturation.
- Unused state codes 13-15 -> FETCH next edge with Illegal=1.
- Reset asserted mid-instruction or mid-stall forces RST immediately; no partial write is completed.
- MemRead and MemWrite are never 1 in the same cycle.

Test Plan:
- Reset pulse, release, Mem_Ready=1, Opcode=100011 (lw) -> State sequence 0,1,2,3,4,5,1; RegWrite=1 and MemtoReg=1 only in state 5; Instr_Count=1.
- R-type (000000), then beq (000100), then j (000010), Mem_Ready=1 -> 4+3+3 cycles; ALUOp=2 in state 7; PCWriteCond=1 in state 9; PCSource=2 in state 10; Instr_Count=3.
- sw (101011) with Mem_Ready low 3 cycles in MEMWR -> State=6 for 4 cycles, MemWrite held 4 cycles, Instr_Count increments only on exit.
- Fetch with Mem_Ready low 2 cycles -> MemRead=1 for 3 cycles; IRWrite/PCWrite high only in the third.
- Opcode=111111 -> DECODE returns to FETCH; Illegal high exactly 1 cycle; Instr_Count unchanged.
- Reset_n=0 during MEMRD stall -> State=0 and all outputs 0 immediately (before the next edge); CNT_W=4 with 17 instructions -> Instr_Count=1.
